// File: rtl/sm83_pkg.sv
// sm83_pkg: shared types and constants for the SM83 core slice.
//   fetch_state_t : fetch-stage sequencer states
//   tstate_t      : T-state index within an M-cycle (T1..T4)
//   CB_PREFIX     : prefix opcode that introduces the second opcode page
//   is_fetch_state: true for states that drive a bus read M-cycle
package sm83_pkg;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    typedef logic [1:0] tstate_t;

    localparam tstate_t T1 = 2'd0;
    localparam tstate_t T2 = 2'd1;
    localparam tstate_t T3 = 2'd2;
    localparam tstate_t T4 = 2'd3;

    typedef enum logic [2:0] {
        S_OPC    = 3'd0,
        S_CB     = 3'd1,
        S_DEC    = 3'd2,
        S_IMM_LO = 3'd3,
        S_IMM_HI = 3'd4,
        S_HALT   = 3'd5
    } fetch_state_t;

    function automatic logic is_fetch_state(input fetch_state_t s);
        return (s == S_OPC) || (s == S_CB) || (s == S_IMM_LO) || (s == S_IMM_HI);
    endfunction

endpackage

// File: rtl/sm83_tstate_ctr.sv
// sm83_tstate_ctr: T-state sequencer, one T-state per clk, wrapping T4 -> T1.
// Ports:
//   clk    in   core clock
//   rst    in   synchronous active-high reset (returns to T1)
//   stall  in   hold at T3 while asserted (ignored in other T-states)
//   tstate out  current T-state, 0=T1 .. 3=T4
//   is_t3  out  tstate == T3
//   is_t4  out  tstate == T4
module sm83_tstate_ctr
    import sm83_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    output logic [1:0] tstate,
    output logic       is_t3,
    output logic       is_t4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            tstate <= T1;
        end else if (!(stall && (tstate == T3))) begin
            tstate <= tstate + 2'd1;
        end
    end

    assign is_t3 = (tstate == T3);
    assign is_t4 = (tstate == T4);

endmodule

// File: rtl/sm83_fetch.sv
// sm83_fetch: SM83 instruction fetch stage.
// Reads opcode, CB-prefixed opcode and immediate bytes in 4-T-state M-cycles,
// owns the PC and hands IR bytes to the decoder over a valid/ready handshake.
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   mem_addr/mem_rd    bus address (= pc) and read strobe (T1..T3 of fetch M-cycles)
//   mem_rdata          read data, captured on the final T3 clk
//   mem_wait           stretches T3 while a read is in progress
//   pc_out             current program counter
//   pc_load/_val       redirect request and target, applied at the next T4
//   ir_valid/ir_ready  IR handshake, ready sampled at T4 only
//   ir_opcode/ir_cb    opcode byte and CB-prefix flag
//   imm_cnt            immediate byte count (0..2, 3 acts as 2), sampled with ir_ready
//   imm_out/imm_valid  assembled immediate {hi,lo} and its one-clk completion pulse
//   halt               park in S_HALT after the current instruction
//   tstate             current T-state
module sm83_fetch
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  CB_OPCODE = CB_PREFIX
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_wait,
    output logic [15:0] pc_out,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [7:0]  ir_opcode,
    output logic        ir_cb,
    input  logic [1:0]  imm_cnt,
    output logic [15:0] imm_out,
    output logic        imm_valid,
    input  logic        halt,
    output logic [1:0]  tstate
);

    fetch_state_t state;
    fetch_state_t done_state;
    logic [15:0]  pc;
    logic [15:0]  redir_target;
    logic         redir_pending;
    logic         redir_now;
    logic [15:0]  redir_dest;
    logic [7:0]   data_lat;
    logic         imm_two;
    logic         fetching;
    logic         stall;
    logic         is_t3;
    logic         is_t4;

    assign fetching = is_fetch_state(state);
    // rst gates the strobe so the bus is quiet for as long as reset is held
    assign mem_rd   = fetching && !is_t4 && !rst;
    assign mem_addr = pc;
    assign pc_out   = pc;
    assign stall    = mem_rd && mem_wait;

    // a request arriving on the T4 clk itself is applied on that same edge
    assign redir_now  = pc_load || redir_pending;
    assign redir_dest = pc_load ? pc_load_val : redir_target;
    assign done_state = halt ? S_HALT : S_OPC;

    sm83_tstate_ctr u_tctr (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall),
        .tstate (tstate),
        .is_t3  (is_t3),
        .is_t4  (is_t4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_OPC;
            pc            <= RESET_PC;
            redir_target  <= '0;
            redir_pending <= 1'b0;
            data_lat      <= '0;
            imm_two       <= 1'b0;
            ir_valid      <= 1'b0;
            ir_opcode     <= '0;
            ir_cb         <= 1'b0;
            imm_out       <= '0;
            imm_valid     <= 1'b0;
        end else begin
            imm_valid <= 1'b0;

            // only the last T3 clk (no wait) delivers the byte
            if (mem_rd && is_t3 && !mem_wait) begin
                data_lat <= mem_rdata;
            end

            if (pc_load) begin
                redir_pending <= 1'b1;
                redir_target  <= pc_load_val;
            end

            if (is_t4) begin
                if (redir_now) begin
                    // overrides the pending-set above when both happen on T4
                    redir_pending <= 1'b0;
                    pc            <= redir_dest;
                    ir_valid      <= 1'b0;
                    state         <= (state == S_HALT && halt) ? S_HALT : S_OPC;
                end else begin
                    if (fetching) begin
                        pc <= pc + 16'd1;
                    end
                    case (state)
                        S_OPC: begin
                            if (data_lat == CB_OPCODE) begin
                                state <= S_CB;
                            end else begin
                                ir_opcode <= data_lat;
                                ir_cb     <= 1'b0;
                                ir_valid  <= 1'b1;
                                state     <= S_DEC;
                            end
                        end
                        S_CB: begin
                            ir_opcode <= data_lat;
                            ir_cb     <= 1'b1;
                            ir_valid  <= 1'b1;
                            state     <= S_DEC;
                        end
                        S_DEC: begin
                            if (ir_ready) begin
                                ir_valid <= 1'b0;
                                if (imm_cnt != 2'd0) begin
                                    imm_two <= imm_cnt[1];
                                    state   <= S_IMM_LO;
                                end else begin
                                    state <= done_state;
                                end
                            end
                        end
                        S_IMM_LO: begin
                            imm_out <= {8'h00, data_lat};
                            if (imm_two) begin
                                state <= S_IMM_HI;
                            end else begin
                                imm_valid <= 1'b1;
                                state     <= done_state;
                            end
                        end
                        S_IMM_HI: begin
                            imm_out[15:8] <= data_lat;
                            imm_valid     <= 1'b1;
                            state         <= done_state;
                        end
                        S_HALT: begin
                            if (!halt) begin
                                state <= S_OPC;
                            end
                        end
                        default: state <= S_OPC;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sm83_fetch.sv
// tb_sm83_fetch: self-checking bench for sm83_fetch.
// A flat 64 KiB memory model answers the bus; each scenario task pushes the IR
// bytes and immediates it expects, and a monitor pops and compares them as the
// DUT raises ir_valid / imm_valid. Tasks also check cycle-exact outputs inline.
module tb_sm83_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_wait;
    logic [15:0] pc_out;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        ir_valid;
    logic        ir_ready;
    logic [7:0]  ir_opcode;
    logic        ir_cb;
    logic [1:0]  imm_cnt;
    logic [15:0] imm_out;
    logic        imm_valid;
    logic        halt;
    logic [1:0]  tstate;

    logic [7:0]  mem [65536];
    logic [8:0]  ir_exp[$];
    logic [15:0] imm_exp[$];
    logic        ir_valid_q;
    int          errors;
    int          checks;

    sm83_fetch #(.RESET_PC(16'h0000), .CB_OPCODE(8'hCB)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_wait    (mem_wait),
        .pc_out      (pc_out),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_opcode   (ir_opcode),
        .ir_cb       (ir_cb),
        .imm_cnt     (imm_cnt),
        .imm_out     (imm_out),
        .imm_valid   (imm_valid),
        .halt        (halt),
        .tstate      (tstate)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard monitor
    always @(negedge clk) begin
        logic [8:0]  e;
        logic [15:0] ei;
        if (!rst) begin
            if (ir_valid && !ir_valid_q) begin
                checks++;
                if (ir_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ir_unexpected got op=%h cb=%b want none", ir_opcode, ir_cb);
                end else begin
                    e = ir_exp.pop_front();
                    if ({ir_opcode, ir_cb} !== e) begin
                        errors++;
                        $display("FAIL ir_byte got op=%h cb=%b want op=%h cb=%b", ir_opcode, ir_cb, e[8:1], e[0]);
                    end
                end
            end
            if (imm_valid) begin
                checks++;
                if (imm_exp.size() == 0) begin
                    errors++;
                    $display("FAIL imm_unexpected got %h want none", imm_out);
                end else begin
                    ei = imm_exp.pop_front();
                    if (imm_out !== ei) begin
                        errors++;
                        $display("FAIL imm_value got %h want %h", imm_out, ei);
                    end
                end
            end
        end
        ir_valid_q = ir_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        #1;
        checks++;
        if (ir_exp.size() != 0 || imm_exp.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got pending ir=%0d imm=%0d want 0 0", name, ir_exp.size(), imm_exp.size());
            ir_exp.delete();
            imm_exp.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", pc_out); end
        checks++; if (tstate !== 2'd0) begin errors++; $display("FAIL rst_tstate got %0d want 0", tstate); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd got %b want 0", mem_rd); end
        checks++; if ({ir_valid, ir_cb, ir_opcode} !== 10'h000) begin errors++; $display("FAIL rst_ir got v=%b cb=%b op=%h want 0", ir_valid, ir_cb, ir_opcode); end
        checks++; if ({imm_valid, imm_out} !== 17'h0) begin errors++; $display("FAIL rst_imm got v=%b imm=%h want 0", imm_valid, imm_out); end
    endtask

    task automatic test_fetch_basic;
        ir_exp.push_back({8'h00, 1'b0});
        rst = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'h0000 || mem_rd !== 1'b1) begin errors++; $display("FAIL basic_first_addr got %h rd=%b want 0000 rd=1", mem_addr, mem_rd); end
        step(3);
        checks++; if (tstate !== 2'd3 || mem_rd !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL basic_t4 got t=%0d rd=%b v=%b want t=3 rd=0 v=0", tstate, mem_rd, ir_valid); end
        step(1);
        checks++; if (ir_valid !== 1'b1 || pc_out !== 16'h0001) begin errors++; $display("FAIL basic_commit got v=%b pc=%h want v=1 pc=0001", ir_valid, pc_out); end
        step(4);
        checks++; if (ir_valid !== 1'b0 || pc_out !== 16'h0001 || mem_rd !== 1'b1) begin errors++; $display("FAIL basic_accept got v=%b pc=%h rd=%b want v=0 pc=0001 rd=1", ir_valid, pc_out, mem_rd); end
        drain("basic");
    endtask

    task automatic test_cb_prefix;
        ir_exp.push_back({8'h37, 1'b1});
        step(4);
        checks++; if (ir_valid !== 1'b0 || pc_out !== 16'h0002 || mem_rd !== 1'b1) begin errors++; $display("FAIL cb_prefix got v=%b pc=%h rd=%b want v=0 pc=0002 rd=1", ir_valid, pc_out, mem_rd); end
        step(4);
        checks++; if (ir_valid !== 1'b1 || ir_opcode !== 8'h37 || ir_cb !== 1'b1 || pc_out !== 16'h0003) begin errors++; $display("FAIL cb_second got v=%b op=%h cb=%b pc=%h want 1 37 1 0003", ir_valid, ir_opcode, ir_cb, pc_out); end
        step(4);
        drain("cb");
    endtask

    task automatic test_imm;
        ir_exp.push_back({8'h21, 1'b0});
        imm_exp.push_back(16'h1234);
        imm_cnt = 2'd2;
        step(16);
        checks++; if (imm_valid !== 1'b1 || imm_out !== 16'h1234 || pc_out !== 16'h0006) begin errors++; $display("FAIL imm2 got v=%b imm=%h pc=%h want 1 1234 0006", imm_valid, imm_out, pc_out); end
        ir_exp.push_back({8'h3E, 1'b0});
        imm_exp.push_back(16'h00A5);
        imm_cnt = 2'd1;
        step(12);
        checks++; if (imm_valid !== 1'b1 || imm_out !== 16'h00A5 || pc_out !== 16'h0008) begin errors++; $display("FAIL imm1 got v=%b imm=%h pc=%h want 1 00a5 0008", imm_valid, imm_out, pc_out); end
        ir_exp.push_back({8'h01, 1'b0});
        imm_exp.push_back(16'hBEEF);
        imm_cnt = 2'd3;
        step(16);
        checks++; if (imm_valid !== 1'b1 || imm_out !== 16'hBEEF || pc_out !== 16'h000B) begin errors++; $display("FAIL imm3 got v=%b imm=%h pc=%h want 1 beef 000b", imm_valid, imm_out, pc_out); end
        imm_cnt = 2'd0;
        drain("imm");
    endtask

    task automatic test_redirect;
        ir_exp.push_back({8'h11, 1'b0});
        imm_cnt = 2'd2;
        step(8);
        checks++; if (mem_addr !== 16'h000C || mem_rd !== 1'b1) begin errors++; $display("FAIL redir_imm_lo got addr=%h rd=%b want 000c 1", mem_addr, mem_rd); end
        imm_cnt = 2'd0;
        step(1);
        pc_load = 1'b1; pc_load_val = 16'h8000;
        step(1);
        pc_load_val = 16'hC000;
        step(1);
        pc_load = 1'b0; pc_load_val = 16'h1111;
        step(1);
        checks++; if (pc_out !== 16'hC000 || mem_addr !== 16'hC000 || mem_rd !== 1'b1 || tstate !== 2'd0) begin errors++; $display("FAIL redir_target got pc=%h addr=%h rd=%b t=%0d want c000 c000 1 0", pc_out, mem_addr, mem_rd, tstate); end
        checks++; if (imm_valid !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL redir_suppress got immv=%b irv=%b want 0 0", imm_valid, ir_valid); end
        step(3);
        pc_load = 1'b1; pc_load_val = 16'hFFFF;
        step(1);
        pc_load = 1'b0;
        checks++; if (pc_out !== 16'hFFFF || tstate !== 2'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL redir_at_t4 got pc=%h t=%0d v=%b want ffff 0 0", pc_out, tstate, ir_valid); end
        drain("redir");
    endtask

    task automatic test_wait_wrap;
        ir_exp.push_back({8'h3C, 1'b0});
        mem_wait = 1'b1;
        step(2);
        checks++; if (tstate !== 2'd2) begin errors++; $display("FAIL wait_early got t=%0d want 2", tstate); end
        step(3);
        checks++; if (tstate !== 2'd2 || mem_rd !== 1'b1) begin errors++; $display("FAIL wait_stall got t=%0d rd=%b want 2 1", tstate, mem_rd); end
        mem_wait = 1'b0;
        mem[16'hFFFF] = 8'h3C;
        step(1);
        checks++; if (tstate !== 2'd3) begin errors++; $display("FAIL wait_release got t=%0d want 3", tstate); end
        step(1);
        checks++; if (ir_valid !== 1'b1 || ir_opcode !== 8'h3C || pc_out !== 16'h0000) begin errors++; $display("FAIL wait_wrap got v=%b op=%h pc=%h want 1 3c 0000", ir_valid, ir_opcode, pc_out); end
        mem_wait = 1'b1;
        step(3);
        checks++; if (tstate !== 2'd3) begin errors++; $display("FAIL wait_idle got t=%0d want 3", tstate); end
        mem_wait = 1'b0;
        step(1);
        drain("wait");
    endtask

    task automatic test_halt;
        int bad;
        bad = 0;
        ir_exp.push_back({8'h00, 1'b0});
        halt = 1'b1;
        step(8);
        checks++; if (ir_valid !== 1'b0 || pc_out !== 16'h0001) begin errors++; $display("FAIL halt_enter got v=%b pc=%h want 0 0001", ir_valid, pc_out); end
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (mem_rd !== 1'b0 || pc_out !== 16'h0001) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_frozen got %0d bad cycles want 0", bad); end
        halt = 1'b0;
        step(4);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001 || tstate !== 2'd0) begin errors++; $display("FAIL halt_resume got rd=%b addr=%h t=%0d want 1 0001 0", mem_rd, mem_addr, tstate); end
        drain("halt");
    endtask

    task automatic test_back_to_back;
        ir_exp.push_back({8'h37, 1'b1});
        ir_ready = 1'b0;
        step(16);
        checks++; if (ir_valid !== 1'b1 || ir_opcode !== 8'h37 || pc_out !== 16'h0003 || mem_rd !== 1'b0) begin errors++; $display("FAIL bp_hold got v=%b op=%h pc=%h rd=%b want 1 37 0003 0", ir_valid, ir_opcode, pc_out, mem_rd); end
        ir_ready = 1'b1;
        step(3);
        ir_ready = 1'b0;
        step(1);
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL bp_ready_off_t4 got v=%b want 1", ir_valid); end
        ir_ready = 1'b1;
        step(4);
        checks++; if (ir_valid !== 1'b0 || mem_rd !== 1'b1 || pc_out !== 16'h0003) begin errors++; $display("FAIL bp_accept got v=%b rd=%b pc=%h want 0 1 0003", ir_valid, mem_rd, pc_out); end
        drain("bp");
    endtask

    task automatic test_reset_mid;
        ir_exp.push_back({8'h21, 1'b0});
        imm_cnt = 2'd2;
        step(12);
        checks++; if (imm_out !== 16'h0034 || imm_valid !== 1'b0 || mem_addr !== 16'h0005 || mem_rd !== 1'b1) begin errors++; $display("FAIL mid_imm_hi got imm=%h v=%b addr=%h rd=%b want 0034 0 0005 1", imm_out, imm_valid, mem_addr, mem_rd); end
        step(1);
        rst = 1'b1;
        step(1);
        checks++; if (pc_out !== 16'h0000 || tstate !== 2'd0 || mem_rd !== 1'b0) begin errors++; $display("FAIL mid_rst_pc got pc=%h t=%0d rd=%b want 0000 0 0", pc_out, tstate, mem_rd); end
        checks++; if ({ir_valid, ir_cb, ir_opcode} !== 10'h000 || {imm_valid, imm_out} !== 17'h0) begin errors++; $display("FAIL mid_rst_out got irv=%b op=%h immv=%b imm=%h want 0", ir_valid, ir_opcode, imm_valid, imm_out); end
        imm_cnt = 2'd0;
        rst = 1'b0;
        drain("mid");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ir_valid_q = 1'b0;
        rst = 1'b1;
        mem_wait = 1'b0;
        pc_load = 1'b0;
        pc_load_val = 16'h0000;
        ir_ready = 1'b1;
        imm_cnt = 2'd0;
        halt = 1'b0;
        for (int unsigned a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0001] = 8'hCB; mem[16'h0002] = 8'h37;
        mem[16'h0003] = 8'h21; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;
        mem[16'h0006] = 8'h3E; mem[16'h0007] = 8'hA5;
        mem[16'h0008] = 8'h01; mem[16'h0009] = 8'hEF; mem[16'h000A] = 8'hBE;
        mem[16'h000B] = 8'h11; mem[16'h000C] = 8'hAA;
        mem[16'hFFFF] = 8'h55;

        test_reset;
        test_fetch_basic;
        test_cb_prefix;
        test_imm;
        test_redirect;
        test_wait_wrap;
        test_halt;
        test_back_to_back;
        test_reset_mid;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
